// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command/response sequencer driving the 16-bit ALU
// Optional shift-add multiply compiled in with macro ALU_SEQ_MUL_EN.
module alu_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_bnegate,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_ITER, DONE} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_ADDSUB = 3'b100;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_bnegate_q, alu_bnegate_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [CW-1:0]      cnt_inc;
  logic [2*WIDTH-1:0] mul_wide;
  logic               mul_lost;
  logic               sticky_nxt;
`endif

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == DONE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_bnegate  = alu_bnegate_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_err      = rsp_err_q;

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    alu_bnegate_d  = alu_bnegate_q;
    err_d          = err_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_err_d      = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    cnt_inc    = cnt_q + CW'(1);
    // Bits of a pushed above the top of the word by this iteration's shift
    mul_wide   = {{WIDTH{1'b0}}, mul_a_q} << cnt_q;
    mul_lost   = (mul_wide >> WIDTH) != '0;
    sticky_nxt = sticky_q | alu_carry | (mul_b_q[cnt_q] & mul_lost);
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d       = cmd_a;
          alu_b_d       = cmd_b;
          alu_op_d      = ALU_AND;
          alu_bnegate_d = 1'b0;
          err_d         = 1'b0;
          state_d       = EXEC;
          case (cmd_op)
            OP_AND: alu_op_d = ALU_AND;
            OP_OR:  alu_op_d = ALU_OR;
            OP_XOR: alu_op_d = ALU_XOR;
            OP_ADD: alu_op_d = ALU_ADDSUB;
            OP_SUB: begin
              alu_op_d      = ALU_ADDSUB;
              alu_bnegate_d = 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              alu_op_d = ALU_ADDSUB;
              alu_a_d  = '0;
              alu_b_d  = cmd_b[0] ? cmd_a : '0;
              mul_a_d  = cmd_a;
              mul_b_d  = cmd_b;
              cnt_d    = '0;
              sticky_d = 1'b0;
              state_d  = MUL_ITER;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end

      EXEC: begin
        if (err_q) begin
          rsp_result_d   = '0;
          rsp_carry_d    = 1'b0;
          rsp_zero_d     = 1'b0;
          rsp_overflow_d = 1'b0;
          rsp_err_d      = 1'b1;
        end else begin
          rsp_result_d   = alu_result;
          rsp_carry_d    = alu_carry;
          rsp_zero_d     = alu_zero;
          rsp_overflow_d = alu_overflow;
          rsp_err_d      = 1'b0;
        end
        state_d = DONE;
      end

`ifdef ALU_SEQ_MUL_EN
      MUL_ITER: begin
        alu_a_d  = alu_result;
        alu_b_d  = mul_b_q[cnt_inc] ? (mul_a_q << cnt_inc) : '0;
        cnt_d    = cnt_inc;
        sticky_d = sticky_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          rsp_result_d   = alu_result;
          rsp_carry_d    = sticky_nxt;
          rsp_overflow_d = sticky_nxt;
          rsp_zero_d     = (alu_result == '0);
          rsp_err_d      = 1'b0;
          state_d        = DONE;
        end
      end
`endif

      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= ALU_AND;
      alu_bnegate_q  <= 1'b0;
      err_q          <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      cnt_q          <= '0;
      sticky_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      alu_bnegate_q  <= alu_bnegate_d;
      err_q          <= err_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_err_q      <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      cnt_q          <= cnt_d;
      sticky_q       <= sticky_d;
`endif
    end
  end

endmodule
